// File: rtl/bridge_1xn_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bridge_1xn_if : CPU data port plus flattened per-slave fan-out bus.
// Rev 1.0
// ----------------------------------------------------------------------------
interface bridge_1xn_if #(
    parameter int NSLV = 2,
    parameter int AW   = 64,
    parameter int DW   = 64
) ();
    // Master (CPU) side
    logic                   m_req;
    logic [DW/8-1:0]        m_we;
    logic [AW-1:0]          m_addr;
    logic [DW-1:0]          m_wdata;
    logic                   m_ready;
    logic                   m_rvalid;
    logic [DW-1:0]          m_rdata;
    logic                   m_err;

    // Slave side, slave 0 in the LSBs of every flattened vector
    logic [NSLV-1:0]        s_req;
    logic [NSLV*DW/8-1:0]   s_we;
    logic [NSLV*AW-1:0]     s_addr;
    logic [NSLV*DW-1:0]     s_wdata;
    logic [NSLV-1:0]        s_ready;
    logic [NSLV-1:0]        s_rvalid;
    logic [NSLV*DW-1:0]     s_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ready, m_rvalid, m_rdata, m_err
    );

    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_ready, s_rvalid, s_rdata
    );

    modport bridge (
        input  m_req, m_we, m_addr, m_wdata,
        output m_ready, m_rvalid, m_rdata, m_err,
        output s_req, s_we, s_addr, s_wdata,
        input  s_ready, s_rvalid, s_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bridge_1xn.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bridge_1xn : one data master to NSLV slaves, base/mask decode, one outstanding
//              transaction. Optional macro BRIDGE_1XN_TIMEOUT_EN adds a watchdog.
// Rev 1.0
// ----------------------------------------------------------------------------
module bridge_1xn #(
    parameter int                 NSLV           = 2,
    parameter int                 AW             = 64,
    parameter int                 DW             = 64,
    parameter logic [NSLV*32-1:0] SLV_BASE       = {32'h0200_0000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK       = {32'hFFFF_0000, 32'h0000_0000},
    parameter int                 TIMEOUT_CYCLES = 255
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    bridge_1xn_if.bridge  bus
);

    localparam int BW = DW / 8;
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_err  = 2'd2;

    logic [1:0]      r_state;
    logic [SW-1:0]   r_sel;

    logic [NSLV-1:0] w_hit_vec;
    logic            w_hit;
    logic [SW-1:0]   w_sel;
    logic            w_sel_ready;
    logic            w_rsp_valid;
    logic [DW-1:0]   w_rsp_data;
    logic            w_timeout;

    // Per-slave address match on the low 32 address bits
    for (genvar k = 0; k < NSLV; k++) begin : g_dec
        assign w_hit_vec[k] =
            (bus.m_addr[31:0] & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32];
    end

    // Scanning downwards lets the lowest-index hit overwrite any higher one
    always_comb begin
        w_hit       = 1'b0;
        w_sel       = '0;
        w_sel_ready = 1'b0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) begin
                w_hit       = 1'b1;
                w_sel       = SW'(k);
                w_sel_ready = bus.s_ready[k];
            end
        end
    end

    always_comb begin
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_sel == SW'(k)) begin
                w_rsp_valid = bus.s_rvalid[k];
                w_rsp_data  = bus.s_rdata[k*DW +: DW];
            end
        end
    end

`ifdef BRIDGE_1XN_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Fires in the BUSY cycle whose increment would make the count reach the limit
    assign w_timeout = (r_state == c_st_busy) &&
                       (({1'b0, r_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state != c_st_busy) begin
            r_cnt <= '0;
        end else if (!w_rsp_valid) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES < 0);
`endif

    for (genvar k = 0; k < NSLV; k++) begin : g_bcast
        assign bus.s_addr[k*AW +: AW]  = resetn ? bus.m_addr  : '0;
        assign bus.s_wdata[k*DW +: DW] = resetn ? bus.m_wdata : '0;
    end

    // Master/slave handshake outputs are combinational in the current state
    always_comb begin
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_err    = 1'b0;
        bus.m_rdata  = '0;
        bus.s_req    = '0;
        bus.s_we     = '0;
        if (resetn) begin
            case (r_state)
                c_st_idle: begin
                    if (w_hit) begin
                        bus.m_ready = bus.m_req && w_sel_ready;
                        for (int k = 0; k < NSLV; k++) begin
                            if (w_sel == SW'(k)) begin
                                bus.s_req[k]          = bus.m_req;
                                bus.s_we[k*BW +: BW]  = bus.m_we;
                            end
                        end
                    end else begin
                        bus.m_ready = bus.m_req;
                    end
                end
                c_st_busy: begin
                    if (w_rsp_valid) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = w_rsp_data;
                    end else if (w_timeout) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_err    = 1'b1;
                    end
                end
                c_st_err: begin
                    bus.m_rvalid = 1'b1;
                    bus.m_err    = 1'b1;
                end
                default: begin
                    bus.m_ready = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
            r_sel   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.m_req) begin
                        if (!w_hit) begin
                            r_state <= c_st_err;
                        end else if (w_sel_ready) begin
                            r_state <= c_st_busy;
                            r_sel   <= w_sel;
                        end
                    end
                end
                c_st_busy: begin
                    if (w_rsp_valid || w_timeout) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_err: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bridge_1xn.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bridge_1xn : directed self-checking bench for bridge_1xn (3 slaves).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bridge_1xn;

    localparam int NSLV = 3;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;

    // slave0 CLINT-like window, slave1 0x8xxx_xxxx, slave2 0x1xxx_xxxx
    localparam logic [NSLV*32-1:0] BASES = {32'h1000_0000, 32'h8000_0000, 32'h0200_0000};
    localparam logic [NSLV*32-1:0] MASKS = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;

    bridge_1xn_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

    bridge_1xn #(
        .NSLV(NSLV), .AW(AW), .DW(DW),
        .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_req    = 1'b0;
        bus.m_we     = '0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.s_ready  = '0;
        bus.s_rvalid = '0;
        bus.s_rdata  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn      = 1'b0;
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h2000_0000;
        bus.s_rvalid = 3'b111;
        #2;
        n_vec++;
        if ({bus.m_ready, bus.m_rvalid, bus.m_err, bus.s_req} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b exp 000000", {bus.m_ready, bus.m_rvalid, bus.m_err, bus.s_req});
        end
        n_vec++;
        if (bus.m_rdata !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h exp 0", bus.m_rdata);
        end
        repeat (2) tick();
        clear_inputs();
        resetn = 1'b1;
        #1;
        n_vec++;
        if ({bus.m_ready, bus.m_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: got %b exp 00", {bus.m_ready, bus.m_rvalid});
        end
        tick();
    endtask

    task automatic test_read();
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h0200_BFF8;
        bus.s_ready = 3'b001;
        #1;
        n_vec++;
        if ({bus.s_req, bus.m_ready, bus.m_rvalid} !== 5'b001_1_0) begin
            n_err++;
            $display("FAIL rd_accept: got %b exp 00110", {bus.s_req, bus.m_ready, bus.m_rvalid});
        end
        n_vec++;
        if (bus.s_addr[1*AW +: AW] !== 64'h0200_BFF8) begin
            n_err++;
            $display("FAIL rd_addr_bcast: got %h exp 0200bff8", bus.s_addr[1*AW +: AW]);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if ({bus.s_req, bus.m_ready, bus.m_rvalid} !== 5'b0) begin
                n_err++;
                $display("FAIL rd_busy_wait%0d: got %b exp 00000", i, {bus.s_req, bus.m_ready, bus.m_rvalid});
            end
            tick();
        end
        bus.s_rvalid           = 3'b001;
        bus.s_rdata[0 +: DW]   = 64'h1234;
        bus.s_rdata[DW +: DW]  = 64'hFFFF_FFFF;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_err, bus.m_ready} !== 3'b100 || bus.m_rdata !== 64'h1234) begin
            n_err++;
            $display("FAIL rd_resp: got v/e/r=%b data=%h exp 100 data=1234",
                     {bus.m_rvalid, bus.m_err, bus.m_ready}, bus.m_rdata);
        end
        tick();
        clear_inputs();
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_resp_pulse: got %b exp 0", bus.m_rvalid);
        end
        tick();
    endtask

    task automatic test_write_stall();
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h8000_0000;
        bus.m_we    = 8'hFF;
        bus.m_wdata = 64'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (bus.m_ready !== 1'b0 || bus.s_req !== 3'b010) begin
                n_err++;
                $display("FAIL wr_stall%0d: ready=%b s_req=%b exp 0 010", i, bus.m_ready, bus.s_req);
            end
            tick();
        end
        n_vec++;
        if (bus.s_we !== 24'h00FF00 || bus.s_wdata[DW +: DW] !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wr_we: s_we=%h wdata1=%h exp 00ff00 deadbeef", bus.s_we, bus.s_wdata[DW +: DW]);
        end
        bus.s_ready = 3'b010;
        #1;
        n_vec++;
        if (bus.m_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_accept: got %b exp 1", bus.m_ready);
        end
        tick();
        bus.s_ready = 3'b000;
        #1;
        n_vec++;
        if (bus.s_we !== 24'h0 || bus.s_req !== 3'b0) begin
            n_err++;
            $display("FAIL wr_busy_gate: s_we=%h s_req=%b exp 0 0", bus.s_we, bus.s_req);
        end
        clear_inputs();
        bus.s_rvalid = 3'b010;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_err} !== 2'b10) begin
            n_err++;
            $display("FAIL wr_resp: got %b exp 10", {bus.m_rvalid, bus.m_err});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_decode();
        bus.m_addr = 64'h1FFF_FFFC;
        bus.m_we   = 8'h0F;
        #1;
        n_vec++;
        if (bus.s_req !== 3'b000 || bus.s_we !== 24'h0F0000) begin
            n_err++;
            $display("FAIL dec_noreq: s_req=%b s_we=%h exp 000 0f0000", bus.s_req, bus.s_we);
        end
        bus.m_req = 1'b1;
        #1;
        n_vec++;
        if (bus.s_req !== 3'b100 || bus.m_ready !== 1'b0) begin
            n_err++;
            $display("FAIL dec_slv2: s_req=%b ready=%b exp 100 0", bus.s_req, bus.m_ready);
        end
        tick();
        // request withdrawn without handshake, then an unmapped neighbour of slave0
        clear_inputs();
        bus.m_req  = 1'b1;
        bus.m_addr = 64'h0201_0000;
        #1;
        n_vec++;
        if (bus.s_req !== 3'b000 || bus.m_ready !== 1'b1 || bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL miss_accept: s_req=%b ready=%b rvalid=%b exp 000 1 0", bus.s_req, bus.m_ready, bus.m_rvalid);
        end
        tick();
        clear_inputs();
        bus.s_rvalid = 3'b111;
        bus.s_rdata  = '1;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_err, bus.m_ready} !== 3'b110 || bus.m_rdata !== 64'h0) begin
            n_err++;
            $display("FAIL miss_resp: got v/e/r=%b data=%h exp 110 0", {bus.m_rvalid, bus.m_err, bus.m_ready}, bus.m_rdata);
        end
        tick();
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_rvalid_ignored: got %b exp 0", bus.m_rvalid);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_ignore_other();
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h8000_0010;
        bus.s_ready = 3'b010;
        tick();
        clear_inputs();
        bus.s_rvalid         = 3'b001;
        bus.s_rdata[0 +: DW] = 64'hAAAA;
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL ign_other: got %b exp 0", bus.m_rvalid);
        end
        tick();
        bus.s_rvalid          = 3'b010;
        bus.s_rdata[DW +: DW] = 64'h5555_0001;
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b1 || bus.m_rdata !== 64'h5555_0001) begin
            n_err++;
            $display("FAIL ign_sel_resp: rvalid=%b data=%h exp 1 55550001", bus.m_rvalid, bus.m_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h0200_0000;
        bus.s_ready = 3'b001;
        tick();
        clear_inputs();
        tick();
        resetn = 1'b0;
        #2;
        n_vec++;
        if ({bus.m_ready, bus.m_rvalid, bus.s_req} !== 5'b0) begin
            n_err++;
            $display("FAIL rstmid_outs: got %b exp 00000", {bus.m_ready, bus.m_rvalid, bus.s_req});
        end
        tick();
        resetn               = 1'b1;
        bus.s_rvalid         = 3'b001;
        bus.s_rdata[0 +: DW] = 64'h77;
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_late_resp: got %b exp 0", bus.m_rvalid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h0200_0040;
        bus.s_ready = 3'b011;
        #1;
        n_vec++;
        if (bus.m_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_acc0: got %b exp 1", bus.m_ready);
        end
        tick();
        bus.m_addr           = 64'h8000_0040;
        bus.s_rvalid         = 3'b001;
        bus.s_rdata[0 +: DW] = 64'h11;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_ready, bus.s_req} !== 5'b10_000 || bus.m_rdata !== 64'h11) begin
            n_err++;
            $display("FAIL b2b_resp0: v/r/sreq=%b data=%h exp 10000 11", {bus.m_rvalid, bus.m_ready, bus.s_req}, bus.m_rdata);
        end
        tick();
        bus.s_rvalid = 3'b000;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_ready, bus.s_req} !== 5'b01_010) begin
            n_err++;
            $display("FAIL b2b_acc1: v/r/sreq=%b exp 01010", {bus.m_rvalid, bus.m_ready, bus.s_req});
        end
        tick();
        clear_inputs();
        bus.s_rvalid          = 3'b010;
        bus.s_rdata[DW +: DW] = 64'h22;
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b1 || bus.m_rdata !== 64'h22) begin
            n_err++;
            $display("FAIL b2b_resp1: rvalid=%b data=%h exp 1 22", bus.m_rvalid, bus.m_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic early;
        bus.m_req   = 1'b1;
        bus.m_addr  = 64'h1000_0000;
        bus.s_ready = 3'b100;
        tick();
        clear_inputs();
        early = 1'b0;
`ifdef BRIDGE_1XN_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            #1;
            early = early | bus.m_rvalid;
            tick();
        end
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_early: got %b exp 0", early);
        end
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_err} !== 2'b11 || bus.m_rdata !== 64'h0) begin
            n_err++;
            $display("FAIL tmo_resp: v/e=%b data=%h exp 11 0", {bus.m_rvalid, bus.m_err}, bus.m_rdata);
        end
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            early = early | bus.m_rvalid;
            tick();
        end
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL notmo_wait: got %b exp 0", early);
        end
        bus.s_rvalid            = 3'b100;
        bus.s_rdata[2*DW +: DW] = 64'h99;
        #1;
        n_vec++;
        if ({bus.m_rvalid, bus.m_err} !== 2'b10 || bus.m_rdata !== 64'h99) begin
            n_err++;
            $display("FAIL notmo_resp: v/e=%b data=%h exp 10 99", {bus.m_rvalid, bus.m_err}, bus.m_rdata);
        end
        tick();
`endif
        clear_inputs();
        #1;
        n_vec++;
        if (bus.m_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_after: got %b exp 0", bus.m_rvalid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_decode();
        test_ignore_other();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
